// File: rtl/moore_seq_gen.sv
// Moore serial pattern transmitter: sends a PAT_W-bit pattern MSB first, reps times, with idle gaps.
// Outputs decode registered state only; start is sampled in IDLE and ignored otherwise.
module moore_seq_gen #(
  parameter int PAT_W = 3,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             y,
  output logic             y_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && (reps != '0)) begin
          pat_d   = pattern;
          rep_d   = reps;
          gap_d   = gap;
          idx_d   = IDX_MAX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (rep_q == REP_W'(1)) begin
          state_d = S_DONE;
        end else begin
          // Another frame follows; a zero gap keeps frames back-to-back.
          rep_d = rep_q - REP_W'(1);
          idx_d = IDX_MAX;
          if (gap_q != '0) begin
            gcnt_d  = gap_q;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign y       = (state_q == S_SHIFT) & pat_q[idx_q];
  assign y_valid = (state_q == S_SHIFT);
  assign busy    = (state_q == S_SHIFT) | (state_q == S_GAP);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: a frame-level queue model checked every cycle, plus literal expectations.
module tb_moore_seq_gen;
  localparam int PAT_W = 3;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [REP_W-1:0] reps = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             y, y_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  moore_seq_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps), .gap(gap),
    .y(y), .y_valid(y_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {y, y_valid, busy, done} per cycle; front entry is the current cycle.
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    bit idle;
    idle = (exp_q.size() == 0);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (!idle) void'(exp_q.pop_front());
      if (idle && start && reps != 0) begin
        for (int r = 0; r < int'(reps); r++) begin
          for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pattern[b], 3'b110});
          if (r != int'(reps) - 1)
            for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (chk_en) begin
      e = (exp_q.size() == 0) ? 4'b0000 : exp_q[0];
      n_cmp++;
      if ({y, y_valid, busy, done} !== e) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t actual=%b required=%b", $time, {y, y_valid, busy, done}, e);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one request and watch it to completion; poke holds start high through busy and DONE.
  task automatic run(input logic [PAT_W-1:0] p, input logic [REP_W-1:0] r, input logic [GAP_W-1:0] g,
                     input bit poke, output int busy_n, output int valid_n, output int done_n,
                     output logic [63:0] ybits, output logic [63:0] vbits);
    bit seen;
    busy_n = 0; valid_n = 0; done_n = 0; ybits = '0; vbits = '0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; pattern = p; reps = r; gap = g;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (busy) begin
        busy_n++;
        ybits = {ybits[62:0], y};
        vbits = {vbits[62:0], y_valid};
      end
      if (y_valid) valid_n++;
      if (done) begin
        done_n++;
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      if (poke) begin
        start = 1'b1; pattern = ~p; reps = 4'd5; gap = 4'd0;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_done actual=none required=done_pulse");
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bn, vn, dn;
    logic [63:0] yb, vb;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs", {60'd0, y, y_valid, busy, done}, 64'h0);

    // 1: single frame 101
    run(3'b101, 4'd1, 4'd0, 1'b0, bn, vn, dn, yb, vb);
    check("t1_busy", 64'(bn), 64'd3);
    check("t1_bits", yb, 64'b101);
    check("t1_done", 64'(dn), 64'd1);
    check("t1_idle", {60'd0, y, y_valid, busy, done}, 64'h0);

    // 2: three back-to-back frames
    run(3'b101, 4'd3, 4'd0, 1'b0, bn, vn, dn, yb, vb);
    check("t2_busy", 64'(bn), 64'd9);
    check("t2_bits", yb, 64'b101101101);
    check("t2_done", 64'(dn), 64'd1);

    // 3: two frames with a 2-cycle gap
    run(3'b110, 4'd2, 4'd2, 1'b0, bn, vn, dn, yb, vb);
    check("t3_busy", 64'(bn), 64'd8);
    check("t3_y", yb, 64'b11000110);
    check("t3_valid", vb, 64'b11100111);

    // 4: reps=0 ignored, then start held high during busy and DONE
    @(negedge clk);
    start = 1'b1; reps = 4'd0; pattern = 3'b111;
    bn = 0; dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) dn++;
    end
    start = 1'b0;
    check("t4_reps0_busy", 64'(bn), 64'd0);
    check("t4_reps0_done", 64'(dn), 64'd0);
    run(3'b011, 4'd2, 4'd1, 1'b1, bn, vn, dn, yb, vb);
    check("t4_poke_busy", 64'(bn), 64'd7);
    check("t4_poke_y", yb, 64'b0110011);
    check("t4_poke_done", 64'(dn), 64'd1);
    bn = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) bn++;
    end
    check("t4_no_queued_start", 64'(bn), 64'd0);

    // 5: reset during the second SHIFT cycle, then reset together with start
    @(negedge clk);
    start = 1'b1; pattern = 3'b111; reps = 4'd3; gap = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_first_bit", {60'd0, y, y_valid, busy, done}, 64'b1110);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_after_reset", {60'd0, y, y_valid, busy, done}, 64'h0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t5_no_done", 64'(dn), 64'd0);
    reset = 1'b1; start = 1'b1; reps = 4'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("t5_reset_start", {60'd0, y, y_valid, busy, done}, 64'h0);

    // 6: maximum reps and gap
    run(3'b101, 4'd15, 4'd15, 1'b0, bn, vn, dn, yb, vb);
    check("t6_busy", 64'(bn), 64'd255);
    check("t6_valid", 64'(vn), 64'd45);
    check("t6_done", 64'(dn), 64'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
